// File: rtl/main_mem_responder_pkg.sv
// Constants, state and operation encodings shared by the main-memory responder
// and the data cache controller that talks to it.
package main_mem_responder_pkg;

  localparam int unsigned TAG_W      = 3;
  localparam int unsigned INDEX_W    = 5;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WORDS      = 4;
  localparam int unsigned ADDR_W     = TAG_W + INDEX_W;
  localparam int unsigned NUM_BLOCKS = 1 << ADDR_W;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mm_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mm_op_e;

  // Power-up content of word w of block blk: {22'd0, blk, w[1:0]}.
  function automatic logic [WORD_W-1:0] init_word(input logic [ADDR_W-1:0] blk,
                                                  input int unsigned       w);
    logic [1:0] wl;
    wl = w[1:0];
    return {22'd0, blk, wl};
  endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-controller <-> main-memory handshake bundle.
interface main_mem_responder_if
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned WORDS = main_mem_responder_pkg::WORDS
) ();

  logic                    MsRead;
  logic                    MsWrite;
  logic [TAG_W-1:0]        tag;
  logic [INDEX_W-1:0]      index;
  logic [1:0]              woff;
  logic [WORD_W-1:0]       wdata;
  logic                    MsReady;
  logic [WORD_W*WORDS-1:0] rblock;
  logic                    MsBusy;

  modport master (
    output MsRead, MsWrite, tag, index, woff, wdata,
    input  MsReady, rblock, MsBusy
  );

  modport slave (
    input  MsRead, MsWrite, tag, index, woff, wdata,
    output MsReady, rblock, MsBusy
  );

endinterface

// File: rtl/main_mem_responder_ram.sv
// Block storage: 256 cache blocks, synchronous read of a full block,
// per-word write enable. Contents survive reset.
module mm_block_ram
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned WORDS = main_mem_responder_pkg::WORDS
) (
  input  logic                    clk,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WORD_W*WORDS-1:0] rd_data,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WORDS-1:0]        wr_en,
  input  logic [WORD_W*WORDS-1:0] wr_data
);

  typedef logic [WORD_W*WORDS-1:0] line_t;
  typedef line_t mem_t [NUM_BLOCKS];

  function automatic mem_t init_image();
    mem_t img;
    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        img[b][w*WORD_W +: WORD_W] = init_word(ADDR_W'(b), w);
      end
    end
    return img;
  endfunction

  mem_t  mem = init_image();
  line_t rd_data_q;

  // Registered block read and word-granular write (read returns old data on collision).
  always_ff @(posedge clk) begin
    rd_data_q <= mem[rd_addr];
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (wr_en[w]) begin
        mem[wr_addr][w*WORD_W +: WORD_W] <= wr_data[w*WORD_W +: WORD_W];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts block reads and write-through word writes
// from the cache controller and completes each after LATENCY cycles.
module main_mem_responder
  import main_mem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned WORDS   = main_mem_responder_pkg::WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  mm_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  mm_op_e                  op_q, op_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [1:0]              woff_q, woff_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic [WORD_W*WORDS-1:0] rblock_q, rblock_d;

  logic [ADDR_W-1:0]       ram_rd_addr;
  logic [WORD_W*WORDS-1:0] ram_rd_data;
  logic [WORDS-1:0]        ram_wr_en;

  // Next-state, counter and capture logic.
  // A counter loaded with 0 (LATENCY=1) skips WAIT so the pulse lands LATENCY
  // edges after accept, the same as the WAIT path for larger latencies.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    woff_d   = woff_q;
    wdata_d  = wdata_q;
    rblock_d = rblock_q;
    unique case (state_q)
      IDLE: begin
        if (bus.MsWrite || bus.MsRead) begin
          op_d    = bus.MsWrite ? OP_WRITE : OP_READ;
          addr_d  = {bus.tag, bus.index};
          woff_d  = bus.woff;
          wdata_d = bus.wdata;
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (op_q == OP_READ) rblock_d = ram_rd_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      woff_q   <= '0;
      wdata_q  <= '0;
      rblock_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      woff_q   <= woff_d;
      wdata_q  <= wdata_d;
      rblock_q <= rblock_d;
    end
  end

  // Write enable for the captured word, active only in a write's DONE cycle.
  always_comb begin
    ram_wr_en = '0;
    if (state_q == DONE && op_q == OP_WRITE) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        if (woff_q == 2'(w)) ram_wr_en[w] = 1'b1;
      end
    end
  end

  // In IDLE the RAM looks up the incoming address so the block is ready even
  // when DONE follows the accept edge directly.
  assign ram_rd_addr = (state_q == IDLE) ? {bus.tag, bus.index} : addr_q;

  mm_block_ram #(
    .WORDS (WORDS)
  ) u_ram (
    .clk     (clk),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data),
    .wr_addr (addr_q),
    .wr_en   (ram_wr_en),
    .wr_data ({WORDS{wdata_q}})
  );

  assign bus.MsReady = (state_q == DONE);
  assign bus.MsBusy  = (state_q != IDLE);
  assign bus.rblock  = (state_q == DONE && op_q == OP_READ) ? ram_rd_data : rblock_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed and randomized checks of main_mem_responder against a
// transaction-level memory model.
module tb_main_mem_responder;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst;

  main_mem_responder_if #(.WORDS(4)) bus0 ();
  main_mem_responder_if #(.WORDS(4)) bus1 ();

  main_mem_responder #(.LATENCY(LAT), .WORDS(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  main_mem_responder #(.LATENCY(1), .WORDS(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  model_mem [256][4];
  logic [127:0] last_rb;

  function automatic logic [127:0] init_blk(input int unsigned b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'(b * 4 + w);
    return r;
  endfunction

  function automatic logic [127:0] model_block(input logic [7:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = model_mem[b][w];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop0();
    bus0.MsRead  = 1'b0;
    bus0.MsWrite = 1'b0;
  endtask

  // One complete transaction on dut0, request held until MsReady.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [2:0] t, input logic [4:0] ix,
                         input logic [1:0] wo, input logic [31:0] wd);
    int lat = -1;
    logic [7:0] b;
    logic [127:0] exp_rb;
    b = {t, ix};
    bus0.MsRead = rd; bus0.MsWrite = wr;
    bus0.tag = t; bus0.index = ix; bus0.woff = wo; bus0.wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) begin
        lat = c;
        break;
      end
      check({name, ":busy_wait"}, 128'(bus0.MsBusy), 128'd1);
    end
    check({name, ":latency"}, 128'(lat), 128'(LAT));
    check({name, ":busy_done"}, 128'(bus0.MsBusy), 128'd1);
    exp_rb = wr ? last_rb : model_block(b);
    check({name, ":rblock_done"}, bus0.rblock, exp_rb);
    drop0();
    if (wr) model_mem[b][wo] = wd;
    else    last_rb = exp_rb;
    tick();
    check({name, ":ready_low"}, 128'(bus0.MsReady), 128'd0);
    check({name, ":busy_low"}, 128'(bus0.MsBusy), 128'd0);
    check({name, ":rblock_hold"}, bus0.rblock, last_rb);
  endtask

  initial begin
    int c2;
    int pulses;
    logic [7:0] b;
    logic [31:0] wd;

    for (int b0 = 0; b0 < 256; b0++)
      for (int w = 0; w < 4; w++) model_mem[b0][w] = 32'(b0 * 4 + w);
    last_rb = '0;

    rst = 1'b0;
    drop0();
    bus0.tag = '0; bus0.index = '0; bus0.woff = '0; bus0.wdata = '0;
    bus1.MsRead = 1'b0; bus1.MsWrite = 1'b0;
    bus1.tag = '0; bus1.index = '0; bus1.woff = '0; bus1.wdata = '0;
    #1;
    check("rst:ready", 128'(bus0.MsReady), 128'd0);
    check("rst:busy", 128'(bus0.MsBusy), 128'd0);
    check("rst:rblock", bus0.rblock, 128'd0);
    check("rst:busy1", 128'(bus1.MsBusy), 128'd0);

    // Release between edges; the request is taken on the very next edge.
    #20 rst = 1'b1;
    run_txn("rd_t3i0", 1'b1, 1'b0, 3'd3, 5'd0, 2'd0, 32'd0);
    run_txn("wr_t3i0", 1'b0, 1'b1, 3'd3, 5'd0, 2'd2, 32'hDEADBEEF);
    run_txn("rd_t3i0_after_wr", 1'b1, 1'b0, 3'd3, 5'd0, 2'd0, 32'd0);

    // Read and write together: write first, held read one IDLE cycle later.
    wd = $urandom;
    b = {3'd5, 5'd9};
    bus0.MsRead = 1'b1; bus0.MsWrite = 1'b1;
    bus0.tag = 3'd5; bus0.index = 5'd9; bus0.woff = 2'd1; bus0.wdata = wd;
    c2 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) begin c2 = c; break; end
    end
    check("both:wr_latency", 128'(c2), 128'(LAT));
    check("both:wr_rblock", bus0.rblock, last_rb);
    bus0.MsWrite = 1'b0;
    model_mem[b][1] = wd;
    c2 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) begin c2 = c; break; end
    end
    check("both:rd_gap", 128'(c2), 128'(LAT + 1));
    check("both:rd_rblock", bus0.rblock, model_block(b));
    last_rb = model_block(b);
    drop0();
    tick();
    check("both:busy_low", 128'(bus0.MsBusy), 128'd0);

    // Request dropped and address changed right after accept.
    b = {3'd6, 5'd17};
    bus0.MsRead = 1'b1; bus0.tag = 3'd6; bus0.index = 5'd17;
    tick();
    bus0.MsRead = 1'b0; bus0.tag = 3'd0; bus0.index = 5'd0;
    c2 = -1;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) begin c2 = c; break; end
    end
    check("drop:latency", 128'(c2), 128'(LAT));
    check("drop:rblock", bus0.rblock, model_block(b));
    last_rb = model_block(b);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) pulses++;
    end
    check("drop:no_second", 128'(pulses), 128'd0);
    check("drop:busy_low", 128'(bus0.MsBusy), 128'd0);

    // Reset in the second WAIT cycle of a write: aborted, word not committed.
    bus0.MsWrite = 1'b1; bus0.tag = 3'd6; bus0.index = 5'd17;
    bus0.woff = 2'd3; bus0.wdata = 32'h12345678;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("abort:busy_async", 128'(bus0.MsBusy), 128'd0);
    check("abort:ready_async", 128'(bus0.MsReady), 128'd0);
    check("abort:rblock_async", bus0.rblock, 128'd0);
    drop0();
    last_rb = '0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus0.MsReady === 1'b1) pulses++;
    end
    check("abort:no_ready", 128'(pulses), 128'd0);
    #2 rst = 1'b1;
    run_txn("abort:readback", 1'b1, 1'b0, 3'd6, 5'd17, 2'd0, 32'd0);

    // Randomized traffic over a few blocks so writes and reads collide.
    for (int i = 0; i < 24; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      run_txn($sformatf("rand%0d", i), (kind != 1), (kind != 0),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom);
    end

    // LATENCY=1 instance with a held read: pulse on every other cycle.
    bus1.MsRead = 1'b1; bus1.tag = 3'd2; bus1.index = 5'd20;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("lat1:ready%0d", c), 128'(bus1.MsReady), 128'(c % 2));
      check($sformatf("lat1:busy%0d", c), 128'(bus1.MsBusy), 128'(c % 2));
      if (c % 2 == 1) check($sformatf("lat1:rblock%0d", c), bus1.rblock, init_blk({3'd2, 5'd20}));
    end
    bus1.MsRead = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
